// File: rtl/io_regs_pkg.sv
`default_nettype none
// ============================================================================
// Package  : io_regs_pkg
// Brief    : Shared constants for io_register_bank: status byte layout,
//            trace register offsets and parameter legality check.
// Revision : 1.0 - initial release
// ============================================================================
package io_regs_pkg;

   // Status byte layout
   localparam int STAT_OVF     = 7;
   localparam int STAT_FULL    = 6;
   localparam int STAT_EMPTY   = 5;
   localparam int STAT_CNT_MSB = 4;

   // Trace register offsets, relative to NUM_CTRL
   localparam int TRACE_DATA_OFS = 0;
   localparam int TRACE_STAT_OFS = 1;

   // Legal configurations: 1..6 control registers, power-of-two FIFO depth
   // of 2..16, and an address wide enough to reach both trace registers.
   function automatic bit params_ok(input int num_ctrl, input int depth, input int addr_w);
      return (num_ctrl >= 1) && (num_ctrl <= 6) &&
             (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0) &&
             (addr_w >= $clog2(num_ctrl + 2));
   endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : strobe_sync
// Brief    : Two-flop synchroniser for an active-low Z80 strobe plus a
//            registered rising-edge detector. All stages reset to 1 so the
//            strobe looks inactive; a rising edge is only reported once the
//            strobe has been genuinely seen high after reset.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic strobe_n,
   output logic sync_n,
   output logic rise,
   output logic armed
);

   logic       r_meta;
   logic       r_sync;
   logic       r_prev;
   logic       r_rise;
   logic [1:0] r_fill;
   logic       r_hi_seen;

   // Synchronise, delay for edge detect, and track when r_sync holds a real sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta    <= 1'b1;
         r_sync    <= 1'b1;
         r_prev    <= 1'b1;
         r_rise    <= 1'b0;
         r_fill    <= 2'b00;
         r_hi_seen <= 1'b0;
      end else begin
         r_meta    <= strobe_n;
         r_sync    <= r_meta;
         r_prev    <= r_sync;
         r_rise    <= r_sync & ~r_prev & r_hi_seen;
         r_fill    <= {r_fill[0], 1'b1};
         r_hi_seen <= r_hi_seen | (r_fill[1] & r_sync);
      end
   end

   assign sync_n = r_sync;
   assign rise   = r_rise;
   assign armed  = r_hi_seen;

endmodule
`default_nettype wire

// File: rtl/io_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_register_bank
// Brief    : NUM_CTRL byte-wide control registers plus an instruction-trace
//            capture of M1 opcode fetches, on a synchronised Z80 I/O bus.
// Config   : define TRACE_FIFO_EN for a DEPTH-entry trace FIFO with status;
//            otherwise the trace is a single overwrite register.
// Revision : 1.0 - initial release
// ============================================================================
module io_register_bank
   import io_regs_pkg::*;
#(
   parameter int NUM_CTRL = 1,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  io_sel,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   output logic                  data_oe,
   input  logic                  wr_n,
   input  logic                  rd_n,
   input  logic                  iorq_n,
   input  logic                  m1_n,
   input  logic                  record_isr,
   output logic [8*NUM_CTRL-1:0] ctrl_out
);

   localparam logic [ADDR_W-1:0] c_trace_data_addr = ADDR_W'(NUM_CTRL + TRACE_DATA_OFS);
   localparam logic [ADDR_W-1:0] c_trace_stat_addr = ADDR_W'(NUM_CTRL + TRACE_STAT_OFS);

   if (!params_ok(NUM_CTRL, DEPTH, ADDR_W)) begin : g_bad_params
      $error("io_register_bank: illegal NUM_CTRL/DEPTH/ADDR_W combination");
   end

   logic w_wr_s, w_wr_rise, w_wr_armed;
   logic w_rd_s, w_rd_rise, w_rd_armed;
   logic w_m1_s, w_m1_rise, w_m1_armed;
   logic w_iorq_s, w_iorq_rise, w_iorq_armed;

   strobe_sync u_wr_sync   (.clk(clk), .reset_n(reset_n), .strobe_n(wr_n),
                            .sync_n(w_wr_s), .rise(w_wr_rise), .armed(w_wr_armed));
   strobe_sync u_rd_sync   (.clk(clk), .reset_n(reset_n), .strobe_n(rd_n),
                            .sync_n(w_rd_s), .rise(w_rd_rise), .armed(w_rd_armed));
   strobe_sync u_m1_sync   (.clk(clk), .reset_n(reset_n), .strobe_n(m1_n),
                            .sync_n(w_m1_s), .rise(w_m1_rise), .armed(w_m1_armed));
   strobe_sync u_iorq_sync (.clk(clk), .reset_n(reset_n), .strobe_n(iorq_n),
                            .sync_n(w_iorq_s), .rise(w_iorq_rise), .armed(w_iorq_armed));

   // Sampling windows; address is latched too because it may move before the commit
   logic w_wr_sample, w_rd_sample, w_m1_sample;
   assign w_wr_sample = ~w_wr_s & ~w_iorq_s & io_sel & w_wr_armed;
   assign w_rd_sample = ~w_rd_s & ~w_iorq_s & io_sel & w_rd_armed;
   assign w_m1_sample = ~w_m1_s & ~w_rd_s & w_iorq_s & w_m1_armed;

   logic [7:0]        r_wr_data;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_wr_hit;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_hit;
   logic [7:0]        r_m1_data;
   logic              r_m1_hit;

   // Capture bus data/address during each strobe window; hit flags mark a qualifying cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_data <= 8'h00;
         r_wr_addr <= '0;
         r_wr_hit  <= 1'b0;
         r_rd_addr <= '0;
         r_rd_hit  <= 1'b0;
         r_m1_data <= 8'h00;
         r_m1_hit  <= 1'b0;
      end else begin
         if (w_wr_sample) begin
            r_wr_data <= data_in;
            r_wr_addr <= addr;
            r_wr_hit  <= 1'b1;
         end else if (w_wr_rise) begin
            r_wr_hit  <= 1'b0;
         end
         if (w_rd_sample) begin
            r_rd_addr <= addr;
            r_rd_hit  <= 1'b1;
         end else if (w_rd_rise) begin
            r_rd_hit  <= 1'b0;
         end
         if (w_m1_sample) begin
            r_m1_data <= data_in;
            r_m1_hit  <= 1'b1;
         end else if (w_m1_rise) begin
            r_m1_hit  <= 1'b0;
         end
      end
   end

   logic w_commit, w_pop_req, w_push_req, w_clr_req;
   assign w_commit   = w_wr_rise & r_wr_hit;
   assign w_pop_req  = w_rd_rise & r_rd_hit & (r_rd_addr == c_trace_data_addr);
   assign w_push_req = w_m1_rise & r_m1_hit & record_isr;
   assign w_clr_req  = w_commit & (r_wr_addr == c_trace_stat_addr);

   logic [8*NUM_CTRL-1:0] r_ctrl;

   // Commit the last sampled byte to the addressed control register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl <= '0;
      end else if (w_commit) begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            if (r_wr_addr == ADDR_W'(k)) r_ctrl[8*k +: 8] <= r_wr_data;
         end
      end
   end

   assign ctrl_out = r_ctrl;

   logic [7:0] w_trace_rdata;
   logic [7:0] w_stat;

`ifdef TRACE_FIFO_EN
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = STAT_CNT_MSB + 1;

   logic [7:0]         r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_ovf;
   logic               w_empty, w_full, w_do_pop, w_do_push;

   // Pop is judged on pre-cycle state; a pop in the same cycle frees room for a push
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_cnt_w'(DEPTH));
   assign w_do_pop  = w_pop_req & ~w_empty;
   assign w_do_push = w_push_req & (~w_full | w_do_pop);

   // Trace storage; entries need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push && !w_clr_req) r_mem[r_wr_ptr] <= r_m1_data;
   end

   // Pointers, occupancy and sticky overflow; a clear overrides everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else if (w_clr_req) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
         if (w_push_req && !w_do_push)    r_ovf   <= 1'b1;
      end
   end

   assign w_trace_rdata = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign w_stat        = {r_ovf, w_full, w_empty, r_count};
`else
   logic r_trace_unused_pop;
   logic [7:0] r_trace;

   // Single trace register: every qualifying fetch overwrites it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_trace <= 8'h00;
      else if (w_push_req) r_trace <= r_m1_data;
   end

   assign r_trace_unused_pop = &{1'b0, w_pop_req, w_clr_req};
   assign w_trace_rdata      = r_trace;
   assign w_stat             = 8'h00;
`endif

   logic w_unused_strobes;
   assign w_unused_strobes = &{1'b0, w_iorq_rise, w_iorq_armed};

   assign data_oe = io_sel & ~iorq_n & ~rd_n;

   // Read mux from raw strobes/address; zero whenever the bus is not being driven
   always_comb begin
      data_out = 8'h00;
      if (data_oe) begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            if (addr == ADDR_W'(k)) data_out = r_ctrl[8*k +: 8];
         end
         if (addr == c_trace_data_addr) data_out = w_trace_rdata;
         if (addr == c_trace_stat_addr) data_out = w_stat;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_io_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_register_bank
// Brief    : Directed scoreboard bench for io_register_bank (NUM_CTRL=2,
//            DEPTH=8). Expectations follow TRACE_FIFO_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_register_bank;

   localparam int NUM_CTRL = 2;
   localparam int DEPTH    = 8;
   localparam int ADDR_W   = 3;

   localparam logic [2:0] A_DATA = 3'd2;
   localparam logic [2:0] A_STAT = 3'd3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        io_sel = 1'b0;
   logic [2:0]  addr = '0;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        wr_n = 1'b1;
   logic        rd_n = 1'b1;
   logic        iorq_n = 1'b1;
   logic        m1_n = 1'b1;
   logic        record_isr = 1'b0;
   logic [15:0] ctrl_out;

   always #5 clk = ~clk;

   io_register_bank #(.NUM_CTRL(NUM_CTRL), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .io_sel(io_sel), .addr(addr),
      .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .wr_n(wr_n), .rd_n(rd_n), .iorq_n(iorq_n), .m1_n(m1_n),
      .record_isr(record_isr), .ctrl_out(ctrl_out)
   );

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] v;
   } rd_exp_t;

   int          n_vec  = 0;
   int          n_fail = 0;
   rd_exp_t     rd_q[$];
   logic [15:0] ctrl_q[$];
   logic [15:0] m_ctrl = '0;
   logic [15:0] mon_prev = '0;
   bit          mon_en = 1'b0;
   bit          prev_oe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every read the DUT drives and every ctrl_out change against the queues
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (data_oe && !prev_oe) begin
            if (rd_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_read: data_oe high with data 0x%02h, none expected", data_out);
            end else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               check($sformatf("read_data[addr %0d]", e.a), 32'(data_out), 32'(e.v));
            end
         end
         if (ctrl_out !== mon_prev) begin
            if (ctrl_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_ctrl: ctrl_out 0x%04h, still expected 0x%04h", ctrl_out, mon_prev);
            end else begin
               check("ctrl_out_change", 32'(ctrl_out), 32'(ctrl_q.pop_front()));
            end
            mon_prev = ctrl_out;
         end
      end
      prev_oe = data_oe;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic io_write(input logic [2:0] a, input logic [7:0] d);
      logic [15:0] m_old;
      int          idx;
      m_old = m_ctrl;
      idx   = int'(a);
      if (idx < NUM_CTRL) m_ctrl[8*idx +: 8] = d;
      if (m_ctrl !== m_old) ctrl_q.push_back(m_ctrl);
      @(negedge clk);
      io_sel = 1'b1; addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
      idle(4);
      wr_n = 1'b1; iorq_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("wr_before_commit", 32'(ctrl_out), 32'(m_old));
      @(posedge clk);
      #1 check("wr_after_commit", 32'(ctrl_out), 32'(m_ctrl));
      @(negedge clk);
      io_sel = 1'b0; data_in = 8'h00;
      idle(4);
   endtask

   task automatic io_read(input logic [2:0] a, input logic [7:0] exp);
      rd_q.push_back('{a: a, v: exp});
      @(negedge clk);
      io_sel = 1'b1; addr = a; iorq_n = 1'b0; rd_n = 1'b0;
      idle(4);
      rd_n = 1'b1; iorq_n = 1'b1;
      @(posedge clk);
      #1;
      check("oe_after_read", 32'(data_oe), 32'h0);
      check("dout_after_read", 32'(data_out), 32'h0);
      idle(3);
      io_sel = 1'b0;
      idle(6);
   endtask

   task automatic fetch(input logic [7:0] op);
      @(negedge clk);
      m1_n = 1'b0; rd_n = 1'b0; data_in = op;
      idle(4);
      m1_n = 1'b1; rd_n = 1'b1;
      idle(3);
      data_in = 8'h00;
      idle(6);
   endtask

   task automatic iack(input logic [7:0] op);
      @(negedge clk);
      m1_n = 1'b0; iorq_n = 1'b0; data_in = op;
      idle(4);
      m1_n = 1'b1; iorq_n = 1'b1;
      idle(3);
      data_in = 8'h00;
      idle(6);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl_out", 32'(ctrl_out), 32'h0);
      check("reset_data_oe", 32'(data_oe), 32'h0);
      check("reset_data_out", 32'(data_out), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      mon_prev = ctrl_out;
      mon_en = 1'b1;
      idle(4);

      // Control registers
      io_write(3'd0, 8'hA5);
      io_write(3'd1, 8'h3C);
      check("ctrl_out_both", 32'(ctrl_out), 32'h3CA5);
      io_read(3'd0, 8'hA5);
      io_read(3'd1, 8'h3C);
      io_read(3'd5, 8'h00);
      io_write(3'd6, 8'h77);

      // Trace capture of three opcodes
      record_isr = 1'b1;
      fetch(8'h01); fetch(8'h02); fetch(8'h03);
`ifdef TRACE_FIFO_EN
      io_read(A_STAT, 8'h03);
      io_read(A_DATA, 8'h01);
      io_read(A_DATA, 8'h02);
      io_read(A_DATA, 8'h03);
      io_read(A_STAT, 8'h20);
`else
      io_read(A_STAT, 8'h00);
      io_read(A_DATA, 8'h03);
      io_read(A_DATA, 8'h03);
`endif

      // Overflow: ten pushes into eight entries
      for (int i = 0; i < 10; i++) fetch(8'h40 + 8'(i));
`ifdef TRACE_FIFO_EN
      io_read(A_STAT, 8'hC8);
      for (int i = 0; i < 8; i++) io_read(A_DATA, 8'h40 + 8'(i));
      io_read(A_STAT, 8'hA0);
      io_read(A_DATA, 8'h00);
      io_write(A_STAT, 8'h5A);
      io_read(A_STAT, 8'h20);
`else
      io_read(A_DATA, 8'h49);
      io_write(A_STAT, 8'h5A);
      io_read(A_STAT, 8'h00);
      io_read(A_DATA, 8'h49);
`endif

      // Interrupt acknowledge and unrecorded fetch never capture
      iack(8'hEE);
      record_isr = 1'b0;
      fetch(8'hDD);
      record_isr = 1'b1;
`ifdef TRACE_FIFO_EN
      io_read(A_STAT, 8'h20);
      io_read(A_DATA, 8'h00);
`else
      io_read(A_DATA, 8'h49);
`endif

      // Pop and push recognised on the same clock with one entry held
      fetch(8'h55);
`ifdef TRACE_FIFO_EN
      io_read(A_STAT, 8'h01);
`endif
      rd_q.push_back('{a: A_DATA, v: 8'h55});
      @(negedge clk);
      io_sel = 1'b1; addr = A_DATA; iorq_n = 1'b0; rd_n = 1'b0;
      idle(4);
      iorq_n = 1'b1; io_sel = 1'b0; m1_n = 1'b0; data_in = 8'h66;
      idle(4);
      m1_n = 1'b1; rd_n = 1'b1;
      idle(3);
      data_in = 8'h00;
      idle(6);
`ifdef TRACE_FIFO_EN
      io_read(A_STAT, 8'h01);
      io_read(A_DATA, 8'h66);
      io_read(A_STAT, 8'h20);
`else
      io_read(A_DATA, 8'h66);
`endif

      // Reset asserted and released while wr_n is held low
      @(negedge clk);
      io_sel = 1'b1; addr = 3'd0; data_in = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
      idle(4);
      ctrl_q.push_back(16'h0000);
      m_ctrl = '0;
      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(4);
      wr_n = 1'b1; iorq_n = 1'b1;
      idle(3);
      io_sel = 1'b0; data_in = 8'h00;
      idle(8);
      check("ctrl_after_reset_write", 32'(ctrl_out), 32'h0);
      io_read(3'd0, 8'h00);

      idle(4);
      check("read_queue_drained", 32'(rd_q.size()), 32'h0);
      check("ctrl_queue_drained", 32'(ctrl_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
